ysyx_squ: RTL
=============

YSYX_SQU -- requirements
Module: ysyx_squ

Interface
REQ-001 SHALL have parameter XLEN, default `YSYX_XLEN, data/address width.
REQ-002 SHALL have parameter SQ_SIZE, default 4, entry count (power of two, >=2).
REQ-003 SHALL have ports clock, input, 1, sole clock; reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, store from EXU in-order queue (IOQ wen & valid).
REQ-005 SHALL have ports in_waddr, input, XLEN, store address; in_wdata, input, XLEN, store data; in_alu, input, 5, store op, width = in_alu[1:0] (0 byte, 1 half, 2 word).
REQ-006 SHALL have port in_ready, output, 1, entry free.
REQ-007 SHALL have port commit_valid, input, 1, ROB retires the oldest uncommitted store this cycle.
REQ-008 SHALL have port flush, input, 1, squash all uncommitted entries.
REQ-009 SHALL have ports ld_addr, input, XLEN, load probe address; ld_conflict, output, 1; ld_fwd_valid, output, 1; ld_fwd_data, output, XLEN.
REQ-010 SHALL have ports mem_valid, output, 1; mem_addr, output, XLEN (word-aligned); mem_wdata, output, XLEN; mem_wstrb, output, 4; mem_ready, input, 1.
REQ-011 SHALL have ports sq_empty, output, 1; sq_full, output, 1.

Function
REQ-012 SHALL be a circular buffer with head/tail/commit pointers of $clog2(SQ_SIZE)+1 bits; wrap bit distinguishes full from empty.
REQ-013 SHALL accept a store when in_valid && in_ready at the clock edge, writing at tail, tail+1; in_ready = !sq_full from registered state only (no same-cycle pop credit).
REQ-014 SHALL advance the commit pointer by one on commit_valid; commit_valid with zero uncommitted entries SHALL be ignored (simulation assertion fires).
REQ-015 SHALL, on flush, set tail = commit pointer in the next cycle; a push in the same cycle SHALL be dropped; commit_valid in the same cycle SHALL be applied before the flush (the committed entry survives).
REQ-016 SHALL drain committed entries via FSM IDLE/REQ: IDLE->REQ when head != commit pointer; in REQ mem_valid=1 with mem_addr/mem_wdata/mem_wstrb stable until mem_ready; on mem_ready head+1 and REQ->IDLE; one store per two cycles minimum.
REQ-017 SHALL form strobes: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; mem_wdata = in_wdata<<(8*addr[1:0]); mem_addr = {addr[XLEN-1:2],2'b00}.
REQ-018 SHALL compute ld_conflict combinationally: any valid entry (head..tail) whose addr[XLEN-1:2] equals ld_addr[XLEN-1:2].
REQ-019 SHALL select the youngest conflicting entry; ld_fwd_valid=1 iff that entry is a word store with exact address equal to ld_addr; ld_fwd_data = its wdata, else 0.
REQ-020 SHALL keep the entry being drained visible to REQ-018 until mem_ready retires it.
REQ-021 SHALL never let flush affect committed entries or an in-flight REQ.
REQ-022 SHALL drive sq_empty = (head == tail), sq_full = (head and tail differ only in wrap bit).

Reset
REQ-023 SHALL, on reset assertion, asynchronously clear head, tail, commit pointer to 0, FSM to IDLE, mem_valid 0, mem_addr/mem_wdata/mem_wstrb 0; sq_empty=1, sq_full=0, in_ready=1, ld_conflict=0, ld_fwd_valid=0, ld_fwd_data=0.
REQ-024 SHALL, on reset mid-drain, drop the outstanding request; entry storage contents need not be cleared.

Configuration
REQ-025 SHALL compile forwarding under macro YSYX_SQ_FWD_EN: defined, REQ-019 applies; undefined, ld_fwd_valid and ld_fwd_data are constant 0 and any ld_conflict requires LSU stall.

Verification
REQ-026 SHALL cover: push word 0x8000_0010/0xDEAD_BEEF, commit, mem_ready=1 -> mem_valid 2nd cycle, mem_addr 0x8000_0010, mem_wstrb 4'hF, then sq_empty=1.
REQ-027 SHALL cover: push byte addr 0x8000_0013 data 0xAB -> mem_wstrb 4'b1000, mem_wdata 0xAB00_0000.
REQ-028 SHALL cover: fill 4 entries -> sq_full=1, in_ready=0; 5th in_valid ignored; commit+drain one -> in_ready=1 next cycle; pointers wrap, order preserved.
REQ-029 SHALL cover: 3 pushes, 1 commit, flush with concurrent push -> only first store drained, sq_empty after drain, dropped push never appears.
REQ-030 SHALL cover: two word stores to 0x100 (0x11, 0x22), ld_addr 0x100 -> ld_fwd_valid=1, ld_fwd_data 0x22; ld_addr 0x102 -> ld_conflict=1, ld_fwd_valid=0; without YSYX_SQ_FWD_EN ld_fwd_valid=0 always.
REQ-031 SHALL cover: reset asserted while mem_valid=1 and mem_ready=0 -> mem_valid 0 immediately, sq_empty=1.

Source files
------------

// File: rtl/ysyx_squ.sv
// ysyx_squ -- store queue between the EXU in-order queue and the data memory.
//
// Stores enter at the tail in program order. The ROB commit signal moves the
// commit pointer forward. Committed stores leave at the head through a
// two-state drain FSM, one memory request at a time. Younger loads probe every
// valid entry for a word-granular address conflict. They can optionally take
// forwarded data from the youngest exact-match word store.
//
// State table (drain FSM)
//   S_IDLE | no request outstanding; launch when head != commit pointer
//   S_REQ  | mem_valid high, request held stable until mem_ready
//
// Ports
//   clock, reset                    sole clock, asynchronous active-high reset
//   in_valid/in_waddr/in_wdata/in_alu/in_ready   store push from the EXU
//   commit_valid                    retire the oldest uncommitted store
//   flush                           squash all uncommitted stores
//   ld_addr/ld_conflict/ld_fwd_valid/ld_fwd_data load probe and forwarding
//   mem_valid/mem_addr/mem_wdata/mem_wstrb/mem_ready   memory write port
//   sq_empty, sq_full               occupancy flags
//
// Build option: define YSYX_SQ_FWD_EN to enable store-to-load forwarding.
// Without it, ld_fwd_valid and ld_fwd_data are tied to 0, and every
// conflict must stall the load.
// The 4-bit strobe assumes a 32-bit data path (XLEN = 32).

`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_squ #(
    parameter int XLEN    = `YSYX_XLEN,
    parameter int SQ_SIZE = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_waddr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [4:0]      in_alu,
    output logic            in_ready,
    input  logic            commit_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] ld_addr,
    output logic            ld_conflict,
    output logic            ld_fwd_valid,
    output logic [XLEN-1:0] ld_fwd_data,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ready,
    output logic            sq_empty,
    output logic            sq_full
);

    localparam int IW = $clog2(SQ_SIZE);
    localparam int PW = IW + 1;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    logic [PW-1:0]   head_q, tail_q, cmt_q;
    logic [PW-1:0]   tail_d, cmt_d, occ;
    state_t          state_q;
    logic            mem_valid_q;
    logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
    logic [3:0]      mem_wstrb_q;

    logic [XLEN-1:0] addr_q [SQ_SIZE];
    logic [XLEN-1:0] data_q [SQ_SIZE];
    logic [1:0]      size_q [SQ_SIZE];

    logic            push, cmt_adv;
    logic [IW-1:0]   hidx, idx;
    logic            conflict, fwd_v;
    logic [XLEN-1:0] fwd_d;
    logic            unused_alu;

    // Only the access size in in_alu[1:0] matters for a store.
    assign unused_alu = ^in_alu[4:2];

    assign sq_empty = (head_q == tail_q);
    assign sq_full  = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
    assign in_ready = !sq_full;
    assign occ      = tail_q - head_q;
    assign hidx     = head_q[IW-1:0];

    // A push in the same cycle as a flush belongs to the squashed path.
    assign push    = in_valid && in_ready && !flush;
    assign cmt_adv = commit_valid && (cmt_q != tail_q);
    assign cmt_d   = cmt_q + PW'(cmt_adv);
    // The flush uses the post-commit pointer, so a store that commits in the flush cycle survives.
    assign tail_d  = flush ? cmt_d : tail_q + PW'(push);

    function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tail_q <= '0;
            cmt_q  <= '0;
        end else begin
            tail_q <= tail_d;
            cmt_q  <= cmt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[tail_q[IW-1:0]] <= in_waddr;
            data_q[tail_q[IW-1:0]] <= in_wdata;
            size_q[tail_q[IW-1:0]] <= in_alu[1:0];
        end
    end

    // Drain FSM. The head entry stays in the queue, and stays visible to
    // the load probe, until memory accepts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (head_q != cmt_q) begin
                        state_q     <= S_REQ;
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= {addr_q[hidx][XLEN-1:2], 2'b00};
                        mem_wdata_q <= data_q[hidx] << {addr_q[hidx][1:0], 3'b000};
                        mem_wstrb_q <= strb_of(size_q[hidx], addr_q[hidx][1:0]);
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        state_q     <= S_IDLE;
                        mem_valid_q <= 1'b0;
                        head_q      <= head_q + PW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    // Walk the queue from oldest to youngest so the last hit wins.
    always_comb begin
        conflict = 1'b0;
        fwd_v    = 1'b0;
        fwd_d    = '0;
        idx      = '0;
        for (int k = 0; k < SQ_SIZE; k++) begin
            idx = hidx + IW'(k);
            if ((PW'(k) < occ) && (addr_q[idx][XLEN-1:2] == ld_addr[XLEN-1:2])) begin
                conflict = 1'b1;
                fwd_v    = size_q[idx][1] && (addr_q[idx] == ld_addr);
                fwd_d    = fwd_v ? data_q[idx] : '0;
            end
        end
    end

    assign ld_conflict = conflict;

`ifdef YSYX_SQ_FWD_EN
    assign ld_fwd_valid = fwd_v;
    assign ld_fwd_data  = fwd_d;
`else
    logic unused_fwd;
    assign unused_fwd   = fwd_v ^ (^fwd_d);
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = '0;
`endif

    a_commit_nonempty : assert property (@(posedge clock) disable iff (reset)
        !(commit_valid && (cmt_q == tail_q)));

endmodule
